// File: rtl/cu_pkg.sv
// cu_pkg: shared state encoding, opcode and ALU control constants for the multicycle control unit
package cu_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_AND   = 3'd2;
  localparam logic [2:0] OP_OR    = 3'd3;
  localparam logic [2:0] OP_LOAD  = 3'd4;
  localparam logic [2:0] OP_STORE = 3'd5;
  localparam logic [2:0] OP_JUMP  = 3'd6;
  localparam logic [2:0] OP_BEQ   = 3'd7;
  localparam logic [1:0] ALU_ADD  = 2'd0;
  localparam logic [1:0] ALU_SUB  = 2'd1;
  localparam logic [1:0] ALU_AND  = 2'd2;
  localparam logic [1:0] ALU_OR   = 2'd3;
endpackage

// File: rtl/cu_op_decode.sv
// cu_op_decode: classifies the latched opcode and selects the ALU operation for EXEC
module cu_op_decode
  import cu_pkg::*;
#(
  parameter int OP_W  = 3,
  parameter int ALU_W = 2
) (
  input  logic [OP_W-1:0]  op_i,
  output logic             is_alu_o,
  output logic             is_load_o,
  output logic             is_store_o,
  output logic             is_jump_o,
  output logic             is_beq_o,
  output logic             is_illegal_o,
  output logic [ALU_W-1:0] alu_sel_o
);
  logic [2:0] code;
  assign code         = op_i[2:0];
  assign is_illegal_o = |(op_i >> 3);
  assign is_alu_o     = !is_illegal_o && !code[2];
  assign is_load_o    = !is_illegal_o && code == OP_LOAD;
  assign is_store_o   = !is_illegal_o && code == OP_STORE;
  assign is_jump_o    = !is_illegal_o && code == OP_JUMP;
  assign is_beq_o     = !is_illegal_o && code == OP_BEQ;
  // Memory ops use the adder for address generation; BEQ compares by subtraction
  assign alu_sel_o    = is_alu_o ? ALU_W'(code[1:0]) : is_beq_o ? ALU_W'(ALU_SUB) : ALU_W'(ALU_ADD);
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FETCH/DECODE/EXEC/MEM/WB sequencer with memory-ready handshake
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int OP_W  = 3,
  parameter int ALU_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [OP_W-1:0]  op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic [ALU_W-1:0] alu_control,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             branch_taken,
  output logic             busy,
  output logic             illegal
);
  state_t            state_q;
  logic [OP_W-1:0]   op_q;
  logic              illegal_q;
  logic              is_alu, is_load, is_store, is_jump, is_beq, is_illegal;
  logic [ALU_W-1:0]  alu_sel;
  logic              redirect;
  state_t            end_s;
  cu_op_decode #(.OP_W(OP_W), .ALU_W(ALU_W)) u_dec (
    .op_i        (op_q),
    .is_alu_o    (is_alu),
    .is_load_o   (is_load),
    .is_store_o  (is_store),
    .is_jump_o   (is_jump),
    .is_beq_o    (is_beq),
    .is_illegal_o(is_illegal),
    .alu_sel_o   (alu_sel)
  );
  assign end_s = run ? S_FETCH : S_IDLE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE:   state_q <= run ? S_FETCH : S_IDLE;
        S_FETCH:
          if (mem_ready) begin
            op_q    <= op;
            state_q <= S_DECODE;
          end
        S_DECODE:
          if (is_illegal) begin
            illegal_q <= 1'b1;
            state_q   <= S_HALT;
          end else state_q <= S_EXEC;
        S_EXEC:   state_q <= is_alu ? S_WB : (is_load || is_store) ? S_MEM : end_s;
        S_MEM:    if (mem_ready) state_q <= is_load ? S_WB : end_s;
        S_WB:     state_q <= end_s;
        S_HALT:   state_q <= S_HALT;
        default:  state_q <= S_IDLE;
      endcase
    end
  end
  always_comb begin
    redirect     = state_q == S_EXEC && (is_jump || (is_beq && zero));
    ir_write     = state_q == S_FETCH && mem_ready;
    pc_write     = ir_write || redirect;
    pc_src       = redirect;
    branch_taken = redirect;
    alu_control  = state_q == S_EXEC ? alu_sel : '0;
    reg_write    = state_q == S_WB;
    mem_read     = state_q == S_FETCH || (state_q == S_MEM && is_load);
    mem_write    = state_q == S_MEM && is_store;
    busy         = state_q != S_IDLE && state_q != S_HALT;
    illegal      = illegal_q;
  end
endmodule
